// File: rtl/banco_de_registradores_param_if.sv
// Register-file access bundle: read ports, two write ports, scoreboard and debug port.
interface banco_de_registradores_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] brp_in_rs;
    logic [ADDR_W-1:0] brp_in_rt;
    logic [DATA_W-1:0] brp_out_R_rs;
    logic [DATA_W-1:0] brp_out_R_rt;
    logic              brp_in_w0_en;
    logic [ADDR_W-1:0] brp_in_w0_addr;
    logic [DATA_W-1:0] brp_in_w0_data;
    logic              brp_in_w1_en;
    logic [ADDR_W-1:0] brp_in_w1_addr;
    logic [DATA_W-1:0] brp_in_w1_data;
    logic              brp_in_busy_set;
    logic [ADDR_W-1:0] brp_in_busy_addr;
    logic              brp_out_busy_rs;
    logic              brp_out_busy_rt;
    logic [ADDR_W-1:0] brp_in_SW;
    logic [DATA_W-1:0] brp_out_reg_para_a_placa;

    modport master (
        output brp_in_rs, brp_in_rt,
        output brp_in_w0_en, brp_in_w0_addr, brp_in_w0_data,
        output brp_in_w1_en, brp_in_w1_addr, brp_in_w1_data,
        output brp_in_busy_set, brp_in_busy_addr, brp_in_SW,
        input  brp_out_R_rs, brp_out_R_rt,
        input  brp_out_busy_rs, brp_out_busy_rt, brp_out_reg_para_a_placa
    );

    modport slave (
        input  brp_in_rs, brp_in_rt,
        input  brp_in_w0_en, brp_in_w0_addr, brp_in_w0_data,
        input  brp_in_w1_en, brp_in_w1_addr, brp_in_w1_data,
        input  brp_in_busy_set, brp_in_busy_addr, brp_in_SW,
        output brp_out_R_rs, brp_out_R_rt,
        output brp_out_busy_rs, brp_out_busy_rt, brp_out_reg_para_a_placa
    );
endinterface

// File: rtl/banco_de_registradores_param.sv
// Parametrised MIPS register file: two combinational reads with optional bypass,
// two prioritised write ports, pending-load scoreboard and registered debug read.
module banco_de_registradores_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic brp_in_clk,
    input logic brp_in_reset_n,
    banco_de_registradores_param_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    word_t               regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    word_t               dbg;
    word_t               rd_a;
    word_t               rd_b;
    logic                w0_ok;
    logic                w1_ok;
    logic                w0_live;
    logic                set_ok;

    function automatic logic is_hard_zero(addr_t a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign w0_ok   = bus.brp_in_w0_en && !is_hard_zero(bus.brp_in_w0_addr);
    assign w1_ok   = bus.brp_in_w1_en && !is_hard_zero(bus.brp_in_w1_addr);
    assign set_ok  = bus.brp_in_busy_set && !is_hard_zero(bus.brp_in_busy_addr);
    // w1 is the load writeback and owns the register on an address collision
    assign w0_live = w0_ok && !(w1_ok && (bus.brp_in_w1_addr == bus.brp_in_w0_addr));

    always_comb begin
        rd_a = is_hard_zero(bus.brp_in_rs) ? '0 : regs[bus.brp_in_rs];
        rd_b = is_hard_zero(bus.brp_in_rt) ? '0 : regs[bus.brp_in_rt];
        if (BYPASS != 0) begin
            if (w1_ok && (bus.brp_in_w1_addr == bus.brp_in_rs)) begin
                rd_a = bus.brp_in_w1_data;
            end else if (w0_ok && (bus.brp_in_w0_addr == bus.brp_in_rs)) begin
                rd_a = bus.brp_in_w0_data;
            end
            if (w1_ok && (bus.brp_in_w1_addr == bus.brp_in_rt)) begin
                rd_b = bus.brp_in_w1_data;
            end else if (w0_ok && (bus.brp_in_w0_addr == bus.brp_in_rt)) begin
                rd_b = bus.brp_in_w0_data;
            end
        end
    end

    // a fresh load issue outranks the writeback that clears the same register
    always_comb begin
        busy_nxt = busy;
        if (w0_ok) busy_nxt[bus.brp_in_w0_addr] = 1'b0;
        if (w1_ok) busy_nxt[bus.brp_in_w1_addr] = 1'b0;
        if (set_ok) busy_nxt[bus.brp_in_busy_addr] = 1'b1;
    end

    always_ff @(posedge brp_in_clk or negedge brp_in_reset_n) begin
        if (!brp_in_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
            dbg  <= '0;
        end else begin
            if (w0_live) regs[bus.brp_in_w0_addr] <= bus.brp_in_w0_data;
            if (w1_ok) regs[bus.brp_in_w1_addr] <= bus.brp_in_w1_data;
            busy <= busy_nxt;
            dbg  <= is_hard_zero(bus.brp_in_SW) ? '0 : regs[bus.brp_in_SW];
        end
    end

    assign bus.brp_out_R_rs             = rd_a;
    assign bus.brp_out_R_rt             = rd_b;
    assign bus.brp_out_busy_rs          = busy[bus.brp_in_rs];
    assign bus.brp_out_busy_rt          = busy[bus.brp_in_rt];
    assign bus.brp_out_reg_para_a_placa = dbg;
endmodule

// File: doc/banco_de_registradores_param.md
Name: banco_de_registradores_param

Overview:
Parametrised register file for the pipelined MIPS datapath, replacing the fixed 32x32 single-write bank. It provides two combinational read ports (rs/rt) with optional write-to-read bypass and two write ports (ALU writeback and load writeback) with fixed priority. Register 0 can be hard-wired to zero. A per-register pending-load scoreboard and a registered debug read port drive the board display.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1: register 0 reads 0, writes and busy-sets to it are ignored; 0: register 0 is ordinary
BYPASS, 1, 1: a same-cycle write is forwarded to rs/rt read data; 0: reads return stored value only

Ports:
brp_in_clk  input  1  clock, all state updates on rising edge
brp_in_reset_n  input  1  asynchronous active-low reset
brp_in_rs  input  ADDR_W  read address A
brp_in_rt  input  ADDR_W  read address B
brp_out_R_rs  output  DATA_W  read data A (combinational)
brp_out_R_rt  output  DATA_W  read data B (combinational)
brp_in_w0_en  input  1  write port 0 enable (ALU writeback)
brp_in_w0_addr  input  ADDR_W  write port 0 address
brp_in_w0_data  input  DATA_W  write port 0 data
brp_in_w1_en  input  1  write port 1 enable (load writeback), priority port
brp_in_w1_addr  input  ADDR_W  write port 1 address
brp_in_w1_data  input  DATA_W  write port 1 data
brp_in_busy_set  input  1  mark brp_in_busy_addr as pending load
brp_in_busy_addr  input  ADDR_W  register to mark pending
brp_out_busy_rs  output  1  pending flag of brp_in_rs (combinational)
brp_out_busy_rt  output  1  pending flag of brp_in_rt (combinational)
brp_in_SW  input  ADDR_W  debug read address (board switches)
brp_out_reg_para_a_placa  output  DATA_W  debug read data, registered

Behaviour:
- Reset (brp_in_reset_n=0, asynchronous): all registers 0, all busy flags 0, brp_out_reg_para_a_placa=0. Read outputs then reflect 0 combinationally. Asserting reset mid-operation discards any same-cycle writes/sets.
- Write: on rising edge, the enabled port writes reg[addr]<=data. If w0 and w1 are both enabled to the same address, w1 wins; w0 is dropped. Different addresses: both written the same edge.
- ZERO_REG=1: any write to address 0 is ignored; reads of address 0 return 0; busy flag 0 is always 0.
- Read: brp_out_R_rs = reg[rs] combinationally, zero latency; likewise rt.
- BYPASS=1: if a write enable is active with address equal to the read address (and not address 0 under ZERO_REG), the output shows the incoming data, with w1 taking precedence over w0. Otherwise the stored value is shown. BYPASS=0: the stored value is always shown; new data is visible the cycle after the edge.
- Scoreboard: busy[a] is set on an edge with brp_in_busy_set and busy_addr=a. It is cleared on an edge where w0 or w1 writes address a. Simultaneous set and clear on the same address: set wins, because a new load is issued. brp_out_busy_rs/rt = busy[rs]/busy[rt], with no bypass.
- Debug port: brp_out_reg_para_a_placa <= reg[SW] (pre-write stored value) each edge; 1-cycle latency; address 0 returns 0 under ZERO_REG.
- Out-of-range addresses cannot occur (NUM_REGS = 2**ADDR_W).

Test Plan:
- Reset: write 0xDEADBEEF to r5, drop reset_n asynchronously mid-cycle -> R_rs(rs=5)=0 immediately, debug=0, busy all 0.
- Dual write: w0 r3=0x11, w1 r4=0x22 same edge -> next cycle rs=3 gives 0x11, rt=4 gives 0x22. Then w0 r7=0xAA and w1 r7=0xBB together -> r7=0xBB.
- Bypass: BYPASS=1, rs=9, w0 r9=0x1234 -> R_rs=0x1234 in the same cycle. BYPASS=0 -> old value in the same cycle, 0x1234 the next cycle.
- Zero register: ZERO_REG=1, w1 r0=0xFFFFFFFF and busy_set r0 -> R_rs(0)=0, busy_rs=0. ZERO_REG=0 -> r0 reads 0xFFFFFFFF.
- Scoreboard: busy_set r8 -> busy_rs(8)=1 next cycle. Then w1 r8 plus busy_set r8 on the same edge -> busy stays 1. Then w0 r8 alone -> busy=0.
- Debug latency: SW=3 with r3=0x55, change r3 to 0x66 -> display shows 0x55, then 0x66 one cycle after the write edge.
